// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states
// and datapath mux select values.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StImmEx  = 4'd9,
    StImmWb  = 4'd10,
    StJump   = 4'd11,
    StFault  = 4'd15
  } state_e;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10,
    AluLogic = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SrcBRt     = 2'b00,
    SrcBFour   = 2'b01,
    SrcBImm    = 2'b10,
    SrcBImmSh2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PcAlu    = 2'b00,
    PcAluOut = 2'b01,
    PcJump   = 2'b10,
    PcRsvd   = 2'b11
  } pc_source_e;

  // States that stall on the memory ready handshake.
  function automatic logic is_wait_state(input state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

  // andi/ori zero-extend and use the opcode-selected logical ALU op.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive memory-wait cycles and flags expiry one cycle before the
// limit would be exceeded, so the FSM can divert to FAULT on that edge.
module mem_watchdog
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic   clk,
  input  logic   rst,
  input  state_e state,
  input  logic   mem_ready,
  output logic   expired
);

  localparam int unsigned Last = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(Last);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_wait;

  always_comb begin
    in_wait = is_wait_state(state);
    cnt_d   = cnt_q;
    // Non-wait states hold the count at zero, so every wait state is entered
    // with a fresh count; saturating keeps a disabled watchdog at zero.
    if (!in_wait || mem_ready) begin
      cnt_d = '0;
    end else if (cnt_q != LastCnt) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired = (TIMEOUT_CYCLES != 0) && in_wait && !mem_ready && (cnt_q == LastCnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with a memory ready handshake, wait watchdog and sticky fault flags.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W       = 6,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                sign_or_zero,
  output logic                retire,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [3:0]          state
);

  state_e     state_q, state_d, out_st, dec_next;
  logic       illegal_q, bus_error_q;
  logic       dec_illegal;
  logic       expired;
  logic [5:0] op6;

  assign op6        = 6'(opcode);
  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign bus_error  = bus_error_q;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_mem_watchdog (
    .clk      (clk),
    .rst      (rst),
    .state    (state_q),
    .mem_ready(mem_ready),
    .expired  (expired)
  );

  always_comb begin
    dec_next    = StFault;
    dec_illegal = 1'b0;
    case (op6)
      OP_LW, OP_SW:             dec_next = StMemAdr;
      OP_RTYPE:                 dec_next = StExec;
      OP_BEQ:                   dec_next = StBranch;
      OP_J:                     dec_next = StJump;
      OP_ADDI, OP_ANDI, OP_ORI: dec_next = StImmEx;
      default:                  dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (expired) state_d = StFault;
      end
      StDecode: state_d = dec_next;
      StMemAdr: state_d = (op6 == OP_LW) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready)    state_d = StMemWb;
        else if (expired) state_d = StFault;
      end
      StMemWr: begin
        if (mem_ready)    state_d = StFetch;
        else if (expired) state_d = StFault;
      end
      StExec:  state_d = StRwb;
      StImmEx: state_d = StImmWb;
      StMemWb, StRwb, StBranch, StImmWb, StJump: state_d = StFetch;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode && dec_illegal) illegal_q <= 1'b1;
      if (expired) bus_error_q <= 1'b1;
    end
  end

  always_comb begin
    // Reset presents FETCH mux selects; strobes are squashed below.
    out_st        = rst ? StFetch : state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBRt;
    alu_op        = AluAdd;
    pc_source     = PcAlu;
    sign_or_zero  = 1'b1;
    retire        = 1'b0;
    unique case (out_st)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: alu_src_b = SrcBImmSh2;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = AluFunct;
      end
      StRwb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        pc_source     = PcAluOut;
        retire        = 1'b1;
      end
      StImmEx: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SrcBImm;
        alu_op       = is_logic_imm(op6) ? AluLogic : AluAdd;
        sign_or_zero = !is_logic_imm(op6);
      end
      StImmWb: begin
        reg_write    = 1'b1;
        retire       = 1'b1;
        sign_or_zero = !is_logic_imm(op6);
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PcJump;
        retire    = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      retire        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle queues the expected
// state and output vector, and a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk, rst, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, sign_or_zero, retire;
  logic       illegal_op, bus_error;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control #(
    .OPCODE_W      (6),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .sign_or_zero (sign_or_zero),
    .retire       (retire),
    .illegal_op   (illegal_op),
    .bus_error    (bus_error),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [19:0] outs;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] obs;

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, sign_or_zero,
                retire, illegal_op, bus_error};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs straight from the state/output table.
  function automatic logic [19:0] exp_out(input logic r, input logic [3:0] st,
                                          input logic [5:0] op, input logic rdy,
                                          input logic ill, input logic berr);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, so, ret, lg;
    logic [1:0] sb, ao, ps;
    pw = 0; pwc = 0; iod = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rd = 0; rw = 0;
    sa = 0; so = 1; ret = 0; sb = 2'b00; ao = 2'b00; ps = 2'b00;
    lg = (op == ANDI) || (op == ORI);
    if (r) begin
      sb = 2'b01;
    end else begin
      case (st)
        4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
        4'd1:  sb = 2'b11;
        4'd2:  begin sa = 1; sb = 2'b10; end
        4'd3:  begin mr = 1; iod = 1; end
        4'd4:  begin m2r = 1; rw = 1; ret = 1; end
        4'd5:  begin mw = 1; iod = 1; ret = rdy; end
        4'd6:  begin sa = 1; ao = 2'b10; end
        4'd7:  begin rd = 1; rw = 1; ret = 1; end
        4'd8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; ret = 1; end
        4'd9:  begin sa = 1; sb = 2'b10; ao = lg ? 2'b11 : 2'b00; so = !lg; end
        4'd10: begin rw = 1; ret = 1; so = !lg; end
        4'd11: begin pw = 1; ps = 2'b10; ret = 1; end
        default: ;
      endcase
    end
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, so, ret, ill, berr};
  endfunction

  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic ill, input logic berr);
    exp_t e;
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    e.tag  = tag;
    e.st   = st;
    e.outs = exp_out(r, st, op, rdy, ill, berr);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_eq({mon_e.tag, "/state"}, 32'(state), 32'(mon_e.st));
      check_eq({mon_e.tag, "/outs"}, 32'(obs), 32'(mon_e.outs));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; opcode = RT; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("reset", 1, RT, 1, 4'd0, 0, 0);

    step("r_fetch", 0, RT, 1, 4'd0, 0, 0);
    step("r_dec",   0, RT, 1, 4'd1, 0, 0);
    step("r_exec",  0, RT, 1, 4'd6, 0, 0);
    step("r_wb",    0, RT, 1, 4'd7, 0, 0);

    step("lw_fetch", 0, LW, 1, 4'd0, 0, 0);
    step("lw_dec",   0, LW, 1, 4'd1, 0, 0);
    step("lw_adr",   0, LW, 1, 4'd2, 0, 0);
    for (int i = 0; i < 3; i++) step("lw_wait", 0, LW, 0, 4'd3, 0, 0);
    step("lw_rd",    0, LW, 1, 4'd3, 0, 0);
    step("lw_wb",    0, LW, 1, 4'd4, 0, 0);

    step("sw_fetch", 0, SW, 1, 4'd0, 0, 0);
    step("sw_dec",   0, SW, 1, 4'd1, 0, 0);
    step("sw_adr",   0, SW, 1, 4'd2, 0, 0);
    step("sw_wr",    0, SW, 1, 4'd5, 0, 0);

    step("ori_fetch", 0, ORI, 1, 4'd0, 0, 0);
    step("ori_dec",   0, ORI, 1, 4'd1, 0, 0);
    step("ori_ex",    0, ORI, 1, 4'd9, 0, 0);
    step("ori_wb",    0, ORI, 1, 4'd10, 0, 0);
    step("addi_fetch", 0, ADDI, 1, 4'd0, 0, 0);
    step("addi_dec",   0, ADDI, 1, 4'd1, 0, 0);
    step("addi_ex",    0, ADDI, 1, 4'd9, 0, 0);
    step("addi_wb",    0, ADDI, 1, 4'd10, 0, 0);
    step("andi_fetch", 0, ANDI, 1, 4'd0, 0, 0);
    step("andi_dec",   0, ANDI, 1, 4'd1, 0, 0);
    step("andi_ex",    0, ANDI, 1, 4'd9, 0, 0);
    step("andi_wb",    0, ANDI, 1, 4'd10, 0, 0);

    step("beq_fetch", 0, BEQ, 1, 4'd0, 0, 0);
    step("beq_dec",   0, BEQ, 1, 4'd1, 0, 0);
    step("beq_br",    0, BEQ, 1, 4'd8, 0, 0);
    step("j_fetch",   0, JMP, 1, 4'd0, 0, 0);
    step("j_dec",     0, JMP, 1, 4'd1, 0, 0);
    step("j_jump",    0, JMP, 1, 4'd11, 0, 0);

    // Fetch stalls for the full limit and then faults.
    for (int i = 0; i < 16; i++) step("wd_fetch", 0, RT, 0, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step("wd_fault", 0, RT, 0, 4'd15, 0, 1);
    step("wd_rst", 1, RT, 0, 4'd15, 0, 1);

    // Ready arriving on the last allowed cycle wins over the watchdog.
    for (int i = 0; i < 15; i++) step("wd_wait", 0, RT, 0, 4'd0, 0, 0);
    step("wd_late", 0, RT, 1, 4'd0, 0, 0);
    step("wd_dec",  0, RT, 1, 4'd1, 0, 0);
    step("wd_exec", 0, RT, 1, 4'd6, 0, 0);
    step("wd_wb",   0, RT, 1, 4'd7, 0, 0);

    step("ill_fetch", 0, BAD, 1, 4'd0, 0, 0);
    step("ill_dec",   0, BAD, 1, 4'd1, 0, 0);
    for (int i = 0; i < 12; i++) step("ill_hold", 0, BAD, 1'(i % 2), 4'd15, 1, 0);
    step("ill_rst",   1, BAD, 1, 4'd15, 1, 0);
    step("ill_clr",   0, RT, 1, 4'd0, 0, 0);
    step("ill_dec2",  0, RT, 1, 4'd1, 0, 0);
    step("ill_exec",  0, RT, 1, 4'd6, 0, 0);
    step("ill_wb",    0, RT, 1, 4'd7, 0, 0);

    step("mid_fetch", 0, SW, 1, 4'd0, 0, 0);
    step("mid_dec",   0, SW, 1, 4'd1, 0, 0);
    step("mid_adr",   0, SW, 1, 4'd2, 0, 0);
    step("mid_wait",  0, SW, 0, 4'd5, 0, 0);
    step("mid_rst",   1, SW, 1, 4'd5, 0, 0);
    step("mid_after", 0, RT, 1, 4'd0, 0, 0);

    @(negedge clk);
    #1;
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
